// File: rtl/alu_seq_pkg.sv
// Shared types and constants for the multi-cycle wide add/subtract sequencer.
package alu_seq_pkg;

  // Default slice width and number of slices per operand
  localparam int DEF_W      = 16;
  localparam int DEF_NSLICE = 4;

  // Controller state encoding
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Bit positions when the five flags are packed into a status word
  localparam int FLAG_PARITY   = 0;
  localparam int FLAG_CARRY    = 1;
  localparam int FLAG_OVERFLOW = 2;
  localparam int FLAG_ZERO     = 3;
  localparam int FLAG_SIGN     = 4;
  localparam int FLAG_COUNT    = 5;

endpackage

// File: rtl/alu_seq_ctrl_if.sv
// Producer/consumer handshake bundle for alu_seq_ctrl.
interface alu_seq_ctrl_if #(
  parameter int N = alu_seq_pkg::DEF_W * alu_seq_pkg::DEF_NSLICE
) ();
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         op;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] sum;
  logic         sign;
  logic         zero;
  logic         overflow;
  logic         carry;
  logic         parity;

  // Side that drives operands and consumes results
  modport master (
    output in_valid, a, b, op, out_ready,
    input  in_ready, out_valid, sum, sign, zero, overflow, carry, parity
  );

  // The sequencer itself
  modport slave (
    input  in_valid, a, b, op, out_ready,
    output in_ready, out_valid, sum, sign, zero, overflow, carry, parity
  );
endinterface

// File: rtl/alu_seq_ctrl_add16_slice.sv
// One W-bit combinational adder slice; also exposes the carry into the MSB
// so the controller can derive signed overflow of the top slice.
module add16_slice #(
  parameter int W = alu_seq_pkg::DEF_W
) (
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  input  logic         cin,
  output logic [W-1:0] s,
  output logic         cout,
  output logic         c_msb
);
  logic [W-1:0] low_sum;
  logic [1:0]   high_sum;

  // Add the lower W-1 bits first to expose the carry into the MSB, then the MSB
  always_comb begin
    low_sum  = {1'b0, x[W-2:0]} + {1'b0, y[W-2:0]} + {{(W-1){1'b0}}, cin};
    c_msb    = low_sum[W-1];
    high_sum = {1'b0, x[W-1]} + {1'b0, y[W-1]} + {1'b0, c_msb};
    s        = {high_sum[0], low_sum[W-2:0]};
    cout     = high_sum[1];
  end
endmodule

// File: rtl/alu_seq_ctrl.sv
// Wide add/subtract sequencer: routes an N-bit operation through a single
// W-bit adder slice one word per clock, LSB word first, and aggregates the
// full-width status flags along the way.
module alu_seq_ctrl
  import alu_seq_pkg::*;
#(
  parameter int W      = DEF_W,
  parameter int NSLICE = DEF_NSLICE
) (
  input logic          clk,
  input logic          rst_n,
  alu_seq_ctrl_if.slave bus
);
  localparam int IDXW = (NSLICE > 1) ? $clog2(NSLICE) : 1;

  // Odd-parity of one result word
  function automatic logic word_parity(input logic [W-1:0] w);
    return ^w;
  endfunction

  state_t                     state_r;
  state_t                     state_nxt;
  logic [IDXW-1:0]            idx_r;
  logic [NSLICE-1:0][W-1:0]   a_r;
  logic [NSLICE-1:0][W-1:0]   b_r;
  logic                       op_r;
  logic                       carry_r;
  logic                       zero_acc_r;
  logic                       par_acc_r;
  logic [NSLICE-1:0][W-1:0]   sum_r;
  logic [FLAG_COUNT-1:0]      flags_r;

  logic                       accept_s;
  logic                       last_s;
  logic [W-1:0]               slice_x_s;
  logic [W-1:0]               slice_y_s;
  logic [W-1:0]               slice_s;
  logic                       slice_cout_s;
  logic                       slice_cmsb_s;
  logic                       word_zero_s;

  add16_slice #(.W(W)) u_slice (
    .x     (slice_x_s),
    .y     (slice_y_s),
    .cin   (carry_r),
    .s     (slice_s),
    .cout  (slice_cout_s),
    .c_msb (slice_cmsb_s)
  );

  // Word select for the shared slice; subtract feeds the inverted b word
  always_comb begin
    accept_s    = (state_r == IDLE) && bus.in_valid;
    last_s      = (idx_r == IDXW'(NSLICE - 1));
    slice_x_s   = a_r[idx_r];
    slice_y_s   = op_r ? ~b_r[idx_r] : b_r[idx_r];
    word_zero_s = (slice_s == {W{1'b0}});
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt;
    end
  end

  // FSM next-state decode
  always_comb begin
    state_nxt = state_r;
    case (state_r)
      IDLE: begin
        if (bus.in_valid) state_nxt = RUN;
        else              state_nxt = IDLE;
      end
      RUN: begin
        if (last_s) state_nxt = DONE;
        else        state_nxt = RUN;
      end
      DONE: begin
        if (bus.out_ready) state_nxt = IDLE;
        else               state_nxt = DONE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Operand capture, word-by-word result build-up and flag accumulation
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_r      <= {IDXW{1'b0}};
      a_r        <= '0;
      b_r        <= '0;
      op_r       <= 1'b0;
      carry_r    <= 1'b0;
      zero_acc_r <= 1'b1;
      par_acc_r  <= 1'b0;
      sum_r      <= '0;
      flags_r    <= {FLAG_COUNT{1'b0}};
    end else if (accept_s) begin
      a_r        <= bus.a;
      b_r        <= bus.b;
      op_r       <= bus.op;
      carry_r    <= bus.op;
      idx_r      <= {IDXW{1'b0}};
      zero_acc_r <= 1'b1;
      par_acc_r  <= 1'b0;
    end else if (state_r == RUN) begin
      sum_r[idx_r] <= slice_s;
      carry_r      <= slice_cout_s;
      zero_acc_r   <= zero_acc_r & word_zero_s;
      par_acc_r    <= par_acc_r ^ word_parity(slice_s);
      if (last_s) begin
        flags_r[FLAG_SIGN]     <= slice_s[W-1];
        flags_r[FLAG_ZERO]     <= zero_acc_r & word_zero_s;
        flags_r[FLAG_CARRY]    <= slice_cout_s;
        flags_r[FLAG_OVERFLOW] <= slice_cmsb_s ^ slice_cout_s;
        flags_r[FLAG_PARITY]   <= par_acc_r ^ word_parity(slice_s);
      end else begin
        idx_r <= idx_r + IDXW'(1);
      end
    end
  end

  // Handshake status and result outputs, all taken from registers
  always_comb begin
    bus.in_ready  = (state_r == IDLE);
    bus.out_valid = (state_r == DONE);
    bus.sum       = sum_r;
    bus.sign      = flags_r[FLAG_SIGN];
    bus.zero      = flags_r[FLAG_ZERO];
    bus.overflow  = flags_r[FLAG_OVERFLOW];
    bus.carry     = flags_r[FLAG_CARRY];
    bus.parity    = flags_r[FLAG_PARITY];
  end

endmodule
